// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl -- ID-stage issue controller.
// A per-register write scoreboard stalls RAW hazards in ID. Serialising
// instructions (CSR/ertn/syscall/break) drain the pipe before and after
// themselves. The controller also owns the ID->EX valid/allowin handshake.
// Optional feature macro: ID_CSR_SERIAL_EN (enables DRAIN/SERIAL sequencing;
// when undefined, serial is ignored and the FSM stays in RUN).
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   id_valid, ex_allowin             handshake inputs
//   reg_{j,k,d}, reg_{j,k,d}_ren     source indices and read enables
//   dest_we, dest, serial            decoded instruction attributes
//   wb_valid, wb_we, wb_dest         retire port
//   flush                            WB flush, kills everything in flight
//   id_ready_go, id_allowin          ID stage handshake outputs
//   id_to_ex_valid                   issue strobe
//   stall_cause                      00 none, 01 RAW, 10 serialise, 11 full
//   inflight_cnt                     issued-not-retired count
//
// state     | meaning
// ST_RUN    | normal issue, scoreboard-gated
// ST_DRAIN  | serial instr waiting for older instructions to retire
// ST_SERIAL | serial instr in flight, younger instructions held
module id_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic             ex_allowin,
  input  logic [4:0]       reg_j,
  input  logic [4:0]       reg_k,
  input  logic [4:0]       reg_d,
  input  logic             reg_j_ren,
  input  logic             reg_k_ren,
  input  logic             reg_d_ren,
  input  logic             dest_we,
  input  logic [4:0]       dest,
  input  logic             serial,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [4:0]       wb_dest,
  input  logic             flush,
  output logic             id_ready_go,
  output logic             id_allowin,
  output logic             id_to_ex_valid,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] inflight_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pend [32];
  logic [CNT_W-1:0] inflight_q, cnt_nxt;
  logic [31:0]      pend_inc, pend_dec;
  logic             serial_in, wb_ret;
  logic             full, raw, serial_block, ready, issue;

`ifdef ID_CSR_SERIAL_EN
  assign serial_in = serial;
`else
  logic unused_serial;
  assign unused_serial = serial;
  assign serial_in     = 1'b0;
`endif

  // A retire coinciding with a flush is discarded.
  assign wb_ret = wb_valid & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (id_valid && serial_in) begin
          if (issue)                   state_nxt = ST_SERIAL;
          else if (inflight_q != '0)   state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN:  if (issue)            state_nxt = ST_SERIAL;
      // Leave as soon as the count is about to hit zero so RUN resumes
      // the cycle after the serial instruction retires.
      ST_SERIAL: if (cnt_nxt == '0)    state_nxt = ST_RUN;
      default:                         state_nxt = ST_RUN;
    endcase
    if (flush) state_nxt = ST_RUN;
  end

  // Output / handshake logic
  always_comb begin
    case (state)
      ST_RUN:   serial_block = serial_in && (inflight_q != '0);
      // The held serial instruction may go once everything older retired.
      ST_DRAIN: serial_block = (inflight_q != '0);
      default:  serial_block = 1'b1;
    endcase

    // A same-cycle retire frees a slot, but does not clear RAW hazards.
    full = (inflight_q == CNT_W'(MAX_INFLIGHT)) && !wb_valid;

    raw = 1'b0;
    if (reg_j_ren && (reg_j != 5'd0) && (pend[reg_j] != '0)) raw = 1'b1;
    if (reg_k_ren && (reg_k != 5'd0) && (pend[reg_k] != '0)) raw = 1'b1;
    if (reg_d_ren && (reg_d != 5'd0) && (pend[reg_d] != '0)) raw = 1'b1;

    ready = !full && !raw && !serial_block;
    issue = id_valid && ready && ex_allowin && !flush && resetn;

    stall_cause = 2'b00;
    if (resetn && id_valid) begin
      if (full)              stall_cause = 2'b11;
      else if (serial_block) stall_cause = 2'b10;
      else if (raw)          stall_cause = 2'b01;
    end
  end

  assign id_ready_go    = ready;
  assign id_allowin     = !id_valid || (ready && ex_allowin);
  assign id_to_ex_valid = issue;
  assign inflight_cnt   = inflight_q;

  // In-flight counter; an illegal retire at zero holds the count at 0.
  always_comb begin
    cnt_nxt = inflight_q;
    case ({issue, wb_ret})
      2'b10:   cnt_nxt = inflight_q + 1'b1;
      2'b01:   if (inflight_q != '0) cnt_nxt = inflight_q - 1'b1;
      default: cnt_nxt = inflight_q;
    endcase
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) inflight_q <= '0;
    else         inflight_q <= cnt_nxt;
  end

  // Scoreboard. Bit 0 of the strobes is never set, so r0 stays clear.
  always_comb begin
    pend_inc = '0;
    pend_dec = '0;
    if (issue && dest_we && (dest != 5'd0))         pend_inc[dest]    = 1'b1;
    if (wb_ret && wb_we && (wb_dest != 5'd0))       pend_dec[wb_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        case ({pend_inc[i], pend_dec[i]})
          2'b10:   pend[i] <= pend[i] + 1'b1;
          2'b01:   if (pend[i] != '0) pend[i] <= pend[i] - 1'b1;
          default: pend[i] <= pend[i];
        endcase
      end
    end
  end

  a_no_retire_when_empty: assert property (@(posedge clk)
    disable iff (!resetn || flush) wb_valid |-> (inflight_q != '0));

  a_no_pend_underflow: assert property (@(posedge clk)
    disable iff (!resetn || flush)
    (wb_valid && wb_we && (wb_dest != 5'd0)) |-> (pend[wb_dest] != '0));

endmodule
